// File: rtl/oa_bias_adder_pkg.sv
// Shared types, saturation bounds and a saturating add for the OA bias/requant path.
package oa_bias_adder_pkg;

    localparam int OA_SIZE       = 16;
    localparam int OA_DATA_WIDTH = 32;

    typedef enum logic {
        WAIT_BIAS = 1'b0,
        RUN       = 1'b1
    } oa_bias_state_t;

    localparam logic signed [OA_DATA_WIDTH-1:0] OA_SAT_MAX = {1'b0, {(OA_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [OA_DATA_WIDTH-1:0] OA_SAT_MIN = {1'b1, {(OA_DATA_WIDTH-1){1'b0}}};

    // One extra bit of headroom; the two top bits disagree only on overflow.
    function automatic logic signed [OA_DATA_WIDTH-1:0] sat_add(
        input logic signed [OA_DATA_WIDTH-1:0] a,
        input logic signed [OA_DATA_WIDTH-1:0] b
    );
        logic signed [OA_DATA_WIDTH:0] s;
        s = {a[OA_DATA_WIDTH-1], a} + {b[OA_DATA_WIDTH-1], b};
        if (s[OA_DATA_WIDTH] != s[OA_DATA_WIDTH-1])
            return s[OA_DATA_WIDTH] ? OA_SAT_MIN : OA_SAT_MAX;
        return s[OA_DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/oa_bias_adder_if.sv
// Row stream (valid/ready/data/last) used for both the accumulator input and the biased output.
interface oa_bias_adder_if
    import oa_bias_adder_pkg::*;
#(
    parameter int SIZE       = OA_SIZE,
    parameter int DATA_WIDTH = OA_DATA_WIDTH
);
    logic                         valid;
    logic                         ready;
    logic                         last;
    logic signed [DATA_WIDTH-1:0] data [SIZE];

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/oa_bias_adder_sat_lane.sv
// One lane of combinational signed saturating addition.
module oa_sat_lane_add #(
    parameter int DATA_WIDTH = 32
) (
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] wide;

    always_comb begin
        wide = {a_i[DATA_WIDTH-1], a_i} + {b_i[DATA_WIDTH-1], b_i};
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1])
            sum_o = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        else
            sum_o = wide[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/oa_bias_adder.sv
// Latches one bias vector per OA tile and adds it, saturating, to each accumulator row.
//   state     | meaning
//   WAIT_BIAS | waiting for the tile's bias (or loading zeros); no rows accepted
//   RUN       | streaming rows through the single output register
module oa_bias_adder
    import oa_bias_adder_pkg::*;
#(
    parameter int SIZE       = OA_SIZE,
    parameter int DATA_WIDTH = OA_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         init_cfg,
    input  logic                         need_bias,
    input  logic                         bias_valid,
    input  logic signed [DATA_WIDTH-1:0] bias_data [SIZE],
    output logic                         bias_taken,
    oa_bias_adder_if.slave               acc_s,
    oa_bias_adder_if.master              out_m,
    output logic                         tile_add_done,
    output logic                         row_overflow
);
    localparam int                CNT_W    = $clog2(SIZE);
    localparam logic [CNT_W-1:0]  ROW_LAST = CNT_W'(SIZE - 1);

    oa_bias_state_t               state_q, state_d;
    logic                         cfg_need_bias_q, cfg_need_bias_d;
    logic signed [DATA_WIDTH-1:0] bias_q [SIZE];
    logic signed [DATA_WIDTH-1:0] bias_d [SIZE];
    logic [CNT_W-1:0]             row_cnt_q, row_cnt_d;
    logic                         overflow_q, overflow_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic signed [DATA_WIDTH-1:0] out_data_q [SIZE];
    logic signed [DATA_WIDTH-1:0] out_data_d [SIZE];
    logic signed [DATA_WIDTH-1:0] sum_w [SIZE];
    logic                         acc_ready;
    logic                         acc_fire;
    logic                         at_limit;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        oa_sat_lane_add #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .a_i   (acc_s.data[gi]),
            .b_i   (bias_q[gi]),
            .sum_o (sum_w[gi])
        );
    end

    always_comb begin
        state_d         = state_q;
        cfg_need_bias_d = cfg_need_bias_q;
        bias_d          = bias_q;
        row_cnt_d       = row_cnt_q;
        overflow_d      = overflow_q;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        out_data_d      = out_data_q;
        bias_taken      = 1'b0;

        // init_cfg gates acc_ready so upstream never sees a row handshake that gets dropped.
        acc_ready     = (state_q == RUN) && (!out_valid_q || out_m.ready) && !init_cfg;
        acc_fire      = acc_s.valid && acc_ready;
        tile_add_done = out_valid_q && out_m.ready && out_last_q;
        at_limit      = (row_cnt_q == ROW_LAST);

        if (out_valid_q && out_m.ready)
            out_valid_d = 1'b0;

        if (init_cfg) begin
            state_d         = WAIT_BIAS;
            cfg_need_bias_d = need_bias;
            row_cnt_d       = '0;
            overflow_d      = 1'b0;
            out_valid_d     = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_BIAS: begin
                    if (!cfg_need_bias_q) begin
                        bias_d  = '{default: '0};
                        state_d = RUN;
                    end else if (bias_valid) begin
                        bias_d     = bias_data;
                        bias_taken = 1'b1;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    if (acc_fire) begin
                        out_data_d  = sum_w;
                        out_valid_d = 1'b1;
                        out_last_d  = acc_s.last || at_limit;
                        if (acc_s.last || at_limit) begin
                            row_cnt_d = '0;
                            state_d   = WAIT_BIAS;
                            if (!acc_s.last)
                                overflow_d = 1'b1;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = WAIT_BIAS;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= WAIT_BIAS;
            cfg_need_bias_q <= 1'b0;
            bias_q          <= '{default: '0};
            row_cnt_q       <= '0;
            overflow_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_data_q      <= '{default: '0};
        end else begin
            state_q         <= state_d;
            cfg_need_bias_q <= cfg_need_bias_d;
            bias_q          <= bias_d;
            row_cnt_q       <= row_cnt_d;
            overflow_q      <= overflow_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            out_data_q      <= out_data_d;
        end
    end

    assign acc_s.ready  = acc_ready;
    assign out_m.valid  = out_valid_q;
    assign out_m.last   = out_last_q;
    assign out_m.data   = out_data_q;
    assign row_overflow = overflow_q;
endmodule

// File: tb/tb_oa_bias_adder.sv
// Directed bench for oa_bias_adder: basic add, saturation, backpressure, no-bias, overflow, interruption.
module tb_oa_bias_adder;
    localparam int N = 16;
    localparam int W = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                init_cfg;
    logic                need_bias;
    logic                bias_valid;
    logic signed [W-1:0] bias_data [N];
    logic                bias_taken;
    logic                tile_add_done;
    logic                row_overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int taken_cnt = 0;
    int done_cnt  = 0;

    oa_bias_adder_if #(.SIZE(N), .DATA_WIDTH(W)) acc_if ();
    oa_bias_adder_if #(.SIZE(N), .DATA_WIDTH(W)) out_if ();

    oa_bias_adder #(.SIZE(N), .DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .init_cfg      (init_cfg),
        .need_bias     (need_bias),
        .bias_valid    (bias_valid),
        .bias_data     (bias_data),
        .bias_taken    (bias_taken),
        .acc_s         (acc_if),
        .out_m         (out_if),
        .tile_add_done (tile_add_done),
        .row_overflow  (row_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (bias_taken)    taken_cnt = taken_cnt + 1;
            if (tile_add_done) done_cnt  = done_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All helpers start and end one time unit after a rising edge.
    task automatic do_cfg(input logic nb);
        init_cfg  = 1'b1;
        need_bias = nb;
        @(posedge clk); #1;
        init_cfg  = 1'b0;
    endtask

    task automatic load_bias(input logic signed [W-1:0] b [N]);
        bias_data  = b;
        bias_valid = 1'b1;
        #1;
        for (int k = 0; k < 20 && !bias_taken; k++) begin
            @(posedge clk); #1;
        end
        if (!bias_taken) begin
            total_cnt++;
            $display("FAIL load_bias_timeout: bias_taken=%0b required 1", bias_taken);
        end
        @(posedge clk); #1;
        bias_valid = 1'b0;
    endtask

    task automatic send_row(input logic signed [W-1:0] d [N], input logic last);
        acc_if.data  = d;
        acc_if.last  = last;
        acc_if.valid = 1'b1;
        #1;
        for (int k = 0; k < 20 && !acc_if.ready; k++) begin
            @(posedge clk); #1;
        end
        if (!acc_if.ready) begin
            total_cnt++;
            $display("FAIL send_row_timeout: acc_ready=%0b required 1", acc_if.ready);
        end
        @(posedge clk); #1;
        acc_if.valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        init_cfg     = 1'b0;
        need_bias    = 1'b0;
        bias_valid   = 1'b0;
        bias_data    = '{default: '0};
        acc_if.valid = 1'b0;
        acc_if.last  = 1'b0;
        acc_if.data  = '{default: '0};
        out_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out_if.valid !== 1'b0) $display("FAIL reset_out_valid: got %0b required 0", out_if.valid);
        else pass_cnt++;
        total_cnt++;
        if (acc_if.ready !== 1'b0) $display("FAIL reset_acc_ready: got %0b required 0", acc_if.ready);
        else pass_cnt++;
        total_cnt++;
        if (row_overflow !== 1'b0 || bias_taken !== 1'b0 || tile_add_done !== 1'b0 || out_if.last !== 1'b0)
            $display("FAIL reset_flags: ovf=%0b taken=%0b done=%0b last=%0b required all 0",
                     row_overflow, bias_taken, tile_add_done, out_if.last);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add;
        int bad;
        logic signed [W-1:0] b [N];
        for (int i = 0; i < N; i++) b[i] = i;
        do_cfg(1'b1);
        taken_cnt  = 0;
        done_cnt   = 0;
        bias_data  = b;
        bias_valid = 1'b1;
        #1;
        total_cnt++;
        if (bias_taken !== 1'b1) $display("FAIL basic_bias_taken: got %0b required 1", bias_taken);
        else pass_cnt++;
        @(posedge clk); #1;
        bias_valid = 1'b0;
        for (int r = 0; r < 4; r++) begin
            acc_if.data  = '{default: 32'sd100};
            acc_if.last  = (r == 3);
            acc_if.valid = 1'b1;
            #1;
            total_cnt++;
            if (acc_if.ready !== 1'b1) $display("FAIL basic_acc_ready row%0d: got %0b required 1", r, acc_if.ready);
            else pass_cnt++;
            @(posedge clk); #1;
            bad = 0;
            for (int i = 0; i < N; i++) if (out_if.data[i] !== 32'(100 + i)) bad++;
            total_cnt++;
            if (out_if.valid !== 1'b1 || out_if.last !== (r == 3) || bad != 0)
                $display("FAIL basic_row%0d: valid=%0b last=%0b lane3=%0d bad_lanes=%0d required valid=1 last=%0b lane3=103",
                         r, out_if.valid, out_if.last, out_if.data[3], bad, (r == 3));
            else pass_cnt++;
        end
        acc_if.valid = 1'b0;
        #1;
        total_cnt++;
        if (tile_add_done !== 1'b1) $display("FAIL basic_tile_done: got %0b required 1", tile_add_done);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_if.valid !== 1'b0 || taken_cnt != 1 || done_cnt != 1)
            $display("FAIL basic_pulses: out_valid=%0b taken=%0d done=%0d required 0/1/1",
                     out_if.valid, taken_cnt, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_saturation;
        int bad;
        logic signed [W-1:0] b [N];
        logic signed [W-1:0] a [N];
        for (int i = 0; i < N; i++) begin
            b[i] = i;
            a[i] = -32'sd50;
        end
        b[0] = 32'sd1;
        b[1] = -32'sd1;
        a[0] = 32'h7FFF_FFFF;
        a[1] = 32'h8000_0000;
        do_cfg(1'b1);
        load_bias(b);
        send_row(a, 1'b1);
        total_cnt++;
        if (out_if.data[0] !== 32'h7FFF_FFFF) $display("FAIL sat_pos: got %h required 7fffffff", out_if.data[0]);
        else pass_cnt++;
        total_cnt++;
        if (out_if.data[1] !== 32'h8000_0000) $display("FAIL sat_neg: got %h required 80000000", out_if.data[1]);
        else pass_cnt++;
        bad = 0;
        for (int i = 2; i < N; i++) if (out_if.data[i] !== 32'(i - 50)) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL sat_others: lane5=%0d bad_lanes=%0d required lane5=-45", out_if.data[5], bad);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int  next_r = 0;
        int  got = 0;
        int  bad;
        bit  hold_prev = 0;
        bit  fire;
        logic signed [W-1:0] held [N];
        logic signed [W-1:0] b [N];
        b = '{default: 32'sd5};
        do_cfg(1'b1);
        load_bias(b);
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_if.ready = !(cyc >= 3 && cyc <= 5);
            acc_if.valid = (next_r < 6);
            for (int i = 0; i < N; i++) acc_if.data[i] = 32'(next_r * 10 + i);
            acc_if.last  = (next_r == 5);
            #1;
            if (out_if.valid && !out_if.ready) begin
                total_cnt++;
                if (acc_if.ready !== 1'b0) $display("FAIL bp_acc_ready cyc%0d: got %0b required 0", cyc, acc_if.ready);
                else pass_cnt++;
            end
            if (hold_prev) begin
                bad = 0;
                for (int i = 0; i < N; i++) if (out_if.data[i] !== held[i]) bad++;
                total_cnt++;
                if (bad != 0 || out_if.valid !== 1'b1)
                    $display("FAIL bp_stable cyc%0d: lane0=%0d valid=%0b required lane0=%0d valid=1",
                             cyc, out_if.data[0], out_if.valid, held[0]);
                else pass_cnt++;
            end
            hold_prev = out_if.valid && !out_if.ready;
            held      = out_if.data;
            if (out_if.valid && out_if.ready) begin
                bad = 0;
                for (int i = 0; i < N; i++) if (out_if.data[i] !== 32'(got * 10 + i + 5)) bad++;
                total_cnt++;
                if (bad != 0 || out_if.last !== (got == 5))
                    $display("FAIL bp_row%0d: lane0=%0d last=%0b required lane0=%0d last=%0b",
                             got, out_if.data[0], out_if.last, got * 10 + 5, (got == 5));
                else pass_cnt++;
                got++;
            end
            fire = acc_if.valid && acc_if.ready;
            @(posedge clk); #1;
            if (fire) next_r++;
        end
        acc_if.valid = 1'b0;
        out_if.ready = 1'b1;
        total_cnt++;
        if (got != 6) $display("FAIL bp_row_count: got %0d rows required 6", got);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_no_bias;
        int bad;
        int taken0;
        logic signed [W-1:0] a [N];
        bias_data  = '{default: 32'sd777};
        bias_valid = 1'b0;
        do_cfg(1'b0);
        taken0 = taken_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) a[i] = 32'(3 - i * 7 - r * 1000);
            send_row(a, r == 1);
            bad = 0;
            for (int i = 0; i < N; i++) if (out_if.data[i] !== a[i]) bad++;
            total_cnt++;
            if (bad != 0 || out_if.valid !== 1'b1)
                $display("FAIL nobias_row%0d: lane2=%0d valid=%0b required lane2=%0d valid=1",
                         r, out_if.data[2], out_if.valid, a[2]);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        total_cnt++;
        if (taken_cnt != taken0) $display("FAIL nobias_taken: got %0d pulses required 0", taken_cnt - taken0);
        else pass_cnt++;
    endtask

    task automatic test_overflow_and_interrupt;
        int bad;
        logic signed [W-1:0] a [N];
        logic signed [W-1:0] b [N];
        b = '{default: '0};
        do_cfg(1'b1);
        load_bias(b);
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++) a[i] = 32'(r * 100 + i);
            send_row(a, 1'b0);
            if (r == N - 2) begin
                total_cnt++;
                if (out_if.last !== 1'b0 || row_overflow !== 1'b0)
                    $display("FAIL ovf_row15: last=%0b ovf=%0b required 0/0", out_if.last, row_overflow);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (out_if.last !== 1'b1 || row_overflow !== 1'b1 || out_if.data[7] !== 32'sd1507)
            $display("FAIL ovf_row16: last=%0b ovf=%0b lane7=%0d required 1/1/1507",
                     out_if.last, row_overflow, out_if.data[7]);
        else pass_cnt++;
        for (int i = 0; i < N; i++) acc_if.data[i] = 32'(1600 + i);
        acc_if.last  = 1'b0;
        acc_if.valid = 1'b1;
        #1;
        total_cnt++;
        if (acc_if.ready !== 1'b0) $display("FAIL ovf_extra_wait: acc_ready=%0b required 0", acc_if.ready);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (acc_if.ready !== 1'b0 || out_if.valid !== 1'b0)
            $display("FAIL ovf_extra_hold: acc_ready=%0b out_valid=%0b required 0/0", acc_if.ready, out_if.valid);
        else pass_cnt++;
        b = '{default: 32'sd2};
        load_bias(b);
        @(posedge clk); #1;
        acc_if.valid = 1'b0;
        total_cnt++;
        if (out_if.valid !== 1'b1 || out_if.data[4] !== 32'sd1606 || row_overflow !== 1'b1)
            $display("FAIL ovf_extra_row: valid=%0b lane4=%0d ovf=%0b required 1/1606/1",
                     out_if.valid, out_if.data[4], row_overflow);
        else pass_cnt++;

        // init_cfg mid-tile with the output stalled
        out_if.ready = 1'b0;
        for (int i = 0; i < N; i++) acc_if.data[i] = 32'(50 * i);
        acc_if.valid = 1'b1;
        init_cfg     = 1'b1;
        need_bias    = 1'b1;
        #1;
        total_cnt++;
        if (acc_if.ready !== 1'b0) $display("FAIL init_acc_ready: got %0b required 0", acc_if.ready);
        else pass_cnt++;
        @(posedge clk); #1;
        init_cfg = 1'b0;
        #1;
        total_cnt++;
        if (out_if.valid !== 1'b0 || row_overflow !== 1'b0 || acc_if.ready !== 1'b0)
            $display("FAIL init_clear: out_valid=%0b ovf=%0b acc_ready=%0b required 0/0/0",
                     out_if.valid, row_overflow, acc_if.ready);
        else pass_cnt++;
        out_if.ready = 1'b1;
        b = '{default: 32'sd9};
        load_bias(b);
        @(posedge clk); #1;
        acc_if.valid = 1'b0;
        total_cnt++;
        if (out_if.valid !== 1'b1 || out_if.data[2] !== 32'sd109)
            $display("FAIL init_resume: valid=%0b lane2=%0d required 1/109", out_if.valid, out_if.data[2]);
        else pass_cnt++;

        // asynchronous reset mid-tile with the output stalled
        out_if.ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_if.valid !== 1'b0 || acc_if.ready !== 1'b0 || out_if.data[2] !== 32'sd0)
            $display("FAIL rst_mid_tile: out_valid=%0b acc_ready=%0b lane2=%0d required 0/0/0",
                     out_if.valid, acc_if.ready, out_if.data[2]);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n        = 1'b1;
        out_if.ready = 1'b1;
        for (int i = 0; i < N; i++) a[i] = 32'(20 + i);
        send_row(a, 1'b1);
        total_cnt++;
        if (out_if.valid !== 1'b1 || out_if.data[3] !== 32'sd23)
            $display("FAIL rst_bias_discarded: valid=%0b lane3=%0d required 1/23", out_if.valid, out_if.data[3]);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_saturation();
        test_backpressure();
        test_no_bias();
        test_overflow_and_interrupt();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
